// File: rtl/rev_serial_alu_seq.sv
// rtl/rev_serial_alu_seq.sv - bit-serial WIDTH-bit ALU sequencer around a reversible 1-bit slice
// Operands stream LSB-first through one slice per clock; result and flags are held until taken.
module rev_serial_alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0]       OP_SUB = 3'b001;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    // Gate library, reduced to the outputs the slice consumes; pass-through lines are not kept.
    function automatic logic fey_q(input logic x, input logic y);
        return x ^ y;
    endfunction

    function automatic logic tof_r(input logic x, input logic y, input logic z);
        return (x & y) ^ z;
    endfunction

    function automatic logic fred_q(input logic c, input logic x, input logic y);
        return c ? y : x;
    endfunction

    // {s, r} of the double Peres gate: r = sum, s = carry when the fourth input is 0.
    function automatic logic [1:0] dpg_sr(input logic pa, input logic pb, input logic pc,
                                          input logic pd);
        return {((pa ^ pb) & pc) ^ (pa & pb) ^ pd, pa ^ pb ^ pc};
    endfunction

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] res_sh;

    logic             a0;
    logic             b0;
    logic [1:0]       add_sr;
    logic             and_bit;
    logic             xor_bit;
    logic             or_bit;
    logic             m00;
    logic             m01;
    logic             m10;
    logic             m11;
    logic             m_lo;
    logic             m_hi;
    logic             slice_bit;
    logic             is_arith;
    logic [WIDTH-1:0] res_final;

    always_comb begin
        a0        = a_sh[0];
        b0        = fey_q(op_q == OP_SUB, b_sh[0]);
        add_sr    = dpg_sr(a0, b0, carry_q, 1'b0);
        and_bit   = tof_r(a0, b0, 1'b0);
        xor_bit   = fey_q(a0, b0);
        or_bit    = fey_q(and_bit, xor_bit);
        // Fredkin mux tree on op; NOR and NOT A share the OR/PASS paths and invert afterwards.
        m00       = add_sr[0];
        m01       = fred_q(op_q[0], and_bit, or_bit);
        m10       = fred_q(op_q[0], xor_bit, or_bit);
        m11       = a0;
        m_lo      = fred_q(op_q[1], m00, m01);
        m_hi      = fred_q(op_q[1], m10, m11);
        slice_bit = fey_q(op_q[2] & op_q[0], fred_q(op_q[2], m_lo, m_hi));
        is_arith  = ~op_q[2] & ~op_q[1];
        res_final = {slice_bit, res_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry_q   <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= '0;
            res_sh    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        op_q     <= op;
                        cnt      <= '0;
                        carry_q  <= (op == OP_SUB);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_sh  <= res_final;
                    carry_q <= add_sr[1];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        // carry_q here is the carry into the MSB slice.
                        result    <= res_final;
                        carry_out <= is_arith & add_sr[1];
                        overflow  <= is_arith & (carry_q ^ add_sr[1]);
                        zero      <= (res_final == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rev_serial_alu_seq.sv
// tb/tb_rev_serial_alu_seq.sv - randomized self-checking bench for rev_serial_alu_seq
// Expected results come from plain arithmetic on the operands.
module tb_rev_serial_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int total = 0;
    int bad   = 0;

    rev_serial_alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {carry, overflow, result}.
    function automatic logic [17:0] model(input logic [2:0] o, input logic [15:0] x,
                                          input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[15:0];
                c = s[16];
                v = (x[15] == y[15]) && (r[15] != x[15]);
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[15] != y[15]) && (r[15] != x[15]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~(x | y);
            3'd6: r = x;
            default: r = ~x;
        endcase
        return {c, v, r};
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input int hold, input bit toggle);
        logic [17:0] e;
        int          n;
        bit          seen;
        logic [15:0] held;
        e = model(o, x, y);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = toggle ? 1'($urandom) : 1'b0;
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            if (toggle) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                op       = 3'($urandom);
                in_valid = 1'($urandom);
            end
            @(posedge clk);
            #1;
            n++;
            if (out_valid) seen = 1;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(W));
        check("result", 32'(result), 32'(e[15:0]));
        check("carry_out", 32'(carry_out), 32'(e[17]));
        check("overflow", 32'(overflow), 32'(e[16]));
        check("zero", 32'(zero), 32'(e[15:0] == 16'd0));
        held = e[15:0];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(held));
            check("hold_flags", {29'd0, carry_out, overflow, zero},
                  {29'd0, e[17], e[16], held == 16'd0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("drop_valid", 32'(out_valid), 32'd0);
        check("back_idle", 32'(in_ready), 32'd1);
        check("result_kept", 32'(result), 32'(held));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(3'd0, 16'h1234, 16'h0FF0, 0, 0);
        run_op(3'd0, 16'hFFFF, 16'h0001, 0, 0);
        run_op(3'd0, 16'h7FFF, 16'h0001, 0, 0);
        run_op(3'd1, 16'h8000, 16'h0001, 0, 0);
        run_op(3'd1, 16'h0001, 16'h0002, 0, 0);
        for (int i = 2; i < 8; i++) run_op(3'(i), 16'hF0F0, 16'hFF00, 0, 0);

        run_op(3'd0, 16'hABCD, 16'h1111, 5, 0);
        run_op(3'd1, 16'h5555, 16'h5555, 0, 1);
        run_op(3'd3, 16'h00F0, 16'h0F00, 1, 1);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                   1'($urandom));
        end

        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'd0;
        a        = 16'h1234;
        b        = 16'h5678;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        run_op(3'd0, 16'h0003, 16'h0004, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
